// File: rtl/bin_erosion_3x3_pkg.sv
// Shared constants and helpers for the 3x3 binary morphology stage.
package bin_morph_pkg;

  localparam logic MORPH_ERODE  = 1'b0;
  localparam logic MORPH_DILATE = 1'b1;
  localparam int   MORPH_LAT    = 2;

  // Position counter width, never below 2 bits so "< 2" compares stay meaningful.
  function automatic int cnt_w(input int n);
    return (n <= 4) ? 2 : $clog2(n);
  endfunction

  // Line-length counter must hold IMG_HDISP+1 to tell over-long lines apart.
  function automatic int len_w(input int n);
    return $clog2(n + 2);
  endfunction

  function automatic int fg_w(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

  function automatic logic combine3(input logic mode, input logic a, input logic b,
                                    input logic c);
    return (mode == MORPH_DILATE) ? (a | b | c) : (a & b & c);
  endfunction

endpackage

// File: rtl/bin_erosion_3x3_if.sv
// Window-in / pixel-out stream bundle between the window generator and this stage.
// Stream protocol: a pixel transfers on every cycle with clken=1 and href=1; there
// is no back-pressure, the consumer must accept each strobed pixel.
interface bin_erosion_3x3_if;
  logic matrix_frame_vsync;
  logic matrix_frame_href;
  logic matrix_frame_clken;
  logic matrix_p11, matrix_p12, matrix_p13;
  logic matrix_p21, matrix_p22, matrix_p23;
  logic matrix_p31, matrix_p32, matrix_p33;
  logic post_frame_vsync;
  logic post_frame_href;
  logic post_frame_clken;
  logic post_img_Bit;

  modport master (
    output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
  );

  modport slave (
    input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
  );
endinterface

// File: rtl/bin_erosion_3x3_pos_ctr.sv
// Input-side column/row position tracking: border mask, vsync edge and sticky line_err.
module morph_pos_ctr
  import bin_morph_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic vsync_i,
  input  logic href_i,
  input  logic clken_i,
  output logic mask_o,
  output logic vsync_rise_o,
  output logic line_err_o
);

  localparam int CW = cnt_w(IMG_HDISP);
  localparam int RW = cnt_w(IMG_VDISP);
  localparam int LW = len_w(IMG_HDISP);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(IMG_HDISP + 1);
  localparam logic [LW-1:0] LEN_OK  = LW'(IMG_HDISP);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [LW-1:0] len_q, len_d;
  logic          href_q, vsync_q, err_q, err_d;
  logic          href_fall;

  assign href_fall    = href_q & ~href_i;
  assign vsync_rise_o = vsync_i & ~vsync_q;
  assign mask_o       = (col_q < CW'(2)) || (row_q < RW'(2));
  assign line_err_o   = err_q;

  always_comb begin
    col_d = col_q;
    len_d = len_q;
    row_d = row_q;
    err_d = err_q;
    if (href_fall) begin
      col_d = '0;
      len_d = '0;
    end else if (href_i && clken_i) begin
      if (col_q != COL_MAX) col_d = col_q + CW'(1);
      if (len_q != LEN_MAX) len_d = len_q + LW'(1);
    end
    if (vsync_rise_o) row_d = '0;
    else if (href_fall && (row_q != ROW_MAX)) row_d = row_q + RW'(1);
    // Clear takes priority over a same-cycle set.
    if (vsync_rise_o) err_d = 1'b0;
    else if (href_fall && (len_q != LEN_OK)) err_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      len_q   <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      len_q   <= len_d;
      href_q  <= href_i;
      vsync_q <= vsync_i;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/bin_erosion_3x3.sv
// 3x3 binary erosion/dilation with border masking and 2-cycle aligned syncs.
// Optional foreground pixel counter enabled by defining ERODE_PIXCNT_EN.
module bin_erosion_3x3
  import bin_morph_pkg::*;
#(
  parameter int   IMG_HDISP  = 640,
  parameter int   IMG_VDISP  = 480,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  bin_erosion_3x3_if.slave bus,
  input  logic morph_sel,
  output logic line_err
`ifdef ERODE_PIXCNT_EN
  ,
  output logic [fg_w(IMG_HDISP, IMG_VDISP)-1:0] fg_count,
  output logic fg_count_vld
`endif
);

  logic mask, vsync_rise, pix_en, href;

  morph_pos_ctr #(.IMG_HDISP(IMG_HDISP), .IMG_VDISP(IMG_VDISP)) u_pos (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .vsync_i      (bus.matrix_frame_vsync),
    .href_i       (bus.matrix_frame_href),
    .clken_i      (bus.matrix_frame_clken),
    .mask_o       (mask),
    .vsync_rise_o (vsync_rise),
    .line_err_o   (line_err)
  );

  assign href   = bus.matrix_frame_href;
  assign pix_en = href & bus.matrix_frame_clken;

  logic                 mode_q, mode_d, mode1_q, mode1_d;
  logic [2:0]           rowp_q, rowp_d;
  logic                 mask1_q, mask1_d, v1_q, v1_d, bit_q, bit_d;
  logic [MORPH_LAT-1:0] vs_sr_q, vs_sr_d, hr_sr_q, hr_sr_d, ck_sr_q, ck_sr_d;

  always_comb begin
    mode_d  = vsync_rise ? morph_sel : mode_q;
    rowp_d  = rowp_q;
    mask1_d = mask1_q;
    mode1_d = mode1_q;
    v1_d    = pix_en;
    if (pix_en) begin
      rowp_d  = {combine3(mode_q, bus.matrix_p31, bus.matrix_p32, bus.matrix_p33),
                 combine3(mode_q, bus.matrix_p21, bus.matrix_p22, bus.matrix_p23),
                 combine3(mode_q, bus.matrix_p11, bus.matrix_p12, bus.matrix_p13)};
      mask1_d = mask;
      mode1_d = mode_q;
    end else if (!href) begin
      rowp_d  = '0;
      mask1_d = 1'b0;
      mode1_d = 1'b0;
    end
    // Stage 2 looks at the stage-1-aligned href so the last pixel of a line survives.
    bit_d = bit_q;
    if (v1_q) bit_d = mask1_q ? BORDER_VAL : combine3(mode1_q, rowp_q[0], rowp_q[1], rowp_q[2]);
    else if (!hr_sr_q[0]) bit_d = 1'b0;
    vs_sr_d = {vs_sr_q[MORPH_LAT-2:0], bus.matrix_frame_vsync};
    hr_sr_d = {hr_sr_q[MORPH_LAT-2:0], href};
    ck_sr_d = {ck_sr_q[MORPH_LAT-2:0], bus.matrix_frame_clken};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= MORPH_ERODE;
      mode1_q <= 1'b0;
      rowp_q  <= '0;
      mask1_q <= 1'b0;
      v1_q    <= 1'b0;
      bit_q   <= 1'b0;
      vs_sr_q <= '0;
      hr_sr_q <= '0;
      ck_sr_q <= '0;
    end else begin
      mode_q  <= mode_d;
      mode1_q <= mode1_d;
      rowp_q  <= rowp_d;
      mask1_q <= mask1_d;
      v1_q    <= v1_d;
      bit_q   <= bit_d;
      vs_sr_q <= vs_sr_d;
      hr_sr_q <= hr_sr_d;
      ck_sr_q <= ck_sr_d;
    end
  end

  assign bus.post_frame_vsync = vs_sr_q[MORPH_LAT-1];
  assign bus.post_frame_href  = hr_sr_q[MORPH_LAT-1];
  assign bus.post_frame_clken = ck_sr_q[MORPH_LAT-1];
  assign bus.post_img_Bit     = bit_q;

`ifdef ERODE_PIXCNT_EN
  localparam int FW = fg_w(IMG_HDISP, IMG_VDISP);

  logic [FW-1:0] cnt_q, cnt_d, fgc_q, fgc_d;
  logic          pv_q, vld_q, vld_d, post_rise, fg_hit;

  assign post_rise = vs_sr_q[MORPH_LAT-1] & ~pv_q;
  assign fg_hit    = ck_sr_q[MORPH_LAT-1] & bit_q;

  always_comb begin
    cnt_d = cnt_q;
    fgc_d = fgc_q;
    vld_d = 1'b0;
    if (post_rise) begin
      fgc_d = cnt_q;
      cnt_d = FW'(fg_hit);
      vld_d = 1'b1;
    end else if (fg_hit) begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      fgc_q <= '0;
      pv_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fgc_q <= fgc_d;
      pv_q  <= vs_sr_q[MORPH_LAT-1];
      vld_q <= vld_d;
    end
  end

  assign fg_count     = fgc_q;
  assign fg_count_vld = vld_q;
`endif

endmodule
